// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and constants for the datapath register bank
package reg_file_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Address width for a given depth; never below one bit.
    function automatic int calc_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// rtl/reg_file_clear_ctrl.sv - sequential clear engine: FSM, entry index and busy flag
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr
);

    clr_state_t    r_state;
    clr_state_t    w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;

    // State and index registers; reset abandons any clear in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: start on request, walk the index, stop after the last entry.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (r_idx == AW'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_idx;

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 1-write 2-read register file with registered reads and clear engine (optional REG_FILE_BYPASS_EN)
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter int               AW        = calc_aw(DEPTH),
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               R0_ZERO   = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITE,
    input  logic [AW-1:0]    ADDR_W,
    input  logic [WIDTH-1:0] DATA_W,
    input  logic             READ,
    input  logic [AW-1:0]    ADDR_R1,
    input  logic [AW-1:0]    ADDR_R2,
    output logic [WIDTH-1:0] DATA_R1,
    output logic [WIDTH-1:0] DATA_R2,
    input  logic             CLEAR_REQ,
    output logic             BUSY
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_data_r1;
    logic [WIDTH-1:0] r_data_r2;
    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_user_we;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_rdata1;
    logic [WIDTH-1:0] w_rdata2;

    reg_file_clear_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_ctrl (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_clear_req (CLEAR_REQ),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    // A clear request in an idle cycle takes priority over a user write or read.
    assign w_user_we = WRITE && !w_busy && !CLEAR_REQ && !(R0_ZERO && (ADDR_W == '0));
    assign w_rd_en   = READ && !w_busy && !CLEAR_REQ;

    // Array update: the clear engine owns the write port while busy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= RESET_VAL;
        end else if (w_user_we) begin
            r_mem[ADDR_W] <= DATA_W;
        end
    end

    // Read port 1 data: stored value, optional write forwarding, register 0 forced to zero.
    always_comb begin
        w_rdata1 = r_mem[ADDR_R1];
`ifdef REG_FILE_BYPASS_EN
        if (w_user_we && (ADDR_W == ADDR_R1)) begin
            w_rdata1 = DATA_W;
        end
`endif
        if (R0_ZERO && (ADDR_R1 == '0)) begin
            w_rdata1 = '0;
        end
    end

    // Read port 2 data: same selection as port 1.
    always_comb begin
        w_rdata2 = r_mem[ADDR_R2];
`ifdef REG_FILE_BYPASS_EN
        if (w_user_we && (ADDR_W == ADDR_R2)) begin
            w_rdata2 = DATA_W;
        end
`endif
        if (R0_ZERO && (ADDR_R2 == '0)) begin
            w_rdata2 = '0;
        end
    end

    // Registered read outputs hold when not enabled.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
        end else if (w_rd_en) begin
            r_data_r1 <= w_rdata1;
            r_data_r2 <= w_rdata2;
        end
    end

    assign DATA_R1 = r_data_r1;
    assign DATA_R2 = r_data_r2;
    assign BUSY    = w_busy;

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised register file with one write port and two read ports, for the datapath register bank.
- Generalises the fixed 32-bit register and 5x32 decoder pair in width, depth and reset value.
- Adds registered reads and a sequential clear engine that rewrites every entry to the reset value, one entry per cycle, with a BUSY indication.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width (derived; do not override).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every register on RESET and by the clear engine.
- R0_ZERO, 1, when 1, register 0 always reads 0 and writes to it are discarded.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- WRITE  input  1  write enable.
- ADDR_W  input  AW  write address.
- DATA_W  input  WIDTH  write data.
- READ  input  1  read enable; updates both read outputs.
- ADDR_R1  input  AW  read port 1 address.
- ADDR_R2  input  AW  read port 2 address.
- DATA_R1  output  WIDTH  registered read data, port 1.
- DATA_R2  output  WIDTH  registered read data, port 2.
- CLEAR_REQ  input  1  one-cycle pulse; starts the clear engine.
- BUSY  output  1  high while the clear engine runs.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers go to RESET_VAL; register 0 reads 0 if R0_ZERO.
  - DATA_R1 and DATA_R2 go to 0.
  - BUSY goes to 0; FSM goes to IDLE; the clear index goes to 0.
- Write: WRITE=1, not BUSY and a rising edge → mem[ADDR_W] <= DATA_W. Takes effect on the next edge.
- Read: READ=1 and not BUSY → on the edge, DATA_R1 <= mem[ADDR_R1] and DATA_R2 <= mem[ADDR_R2]. Latency is 1 cycle.
- READ=0 or BUSY → both outputs hold their last value.
- Both read ports may use the same address; both then return the same data.
- Read and write to the same address in the same cycle, without BYPASS_EN → the read returns the old contents.
- R0_ZERO=1: reads of address 0 return 0 regardless of stored contents; WRITE to address 0 is a no-op.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR on CLEAR_REQ=1. The index is set to 0 and BUSY rises on the same edge.
  - CLEAR: each cycle, mem[index] <= RESET_VAL and the index increments.
  - CLEAR → IDLE on the edge that writes index DEPTH-1. BUSY falls on that edge.
  - BUSY is therefore high for exactly DEPTH cycles.
- While BUSY: WRITE, READ and CLEAR_REQ are all ignored; the data is dropped, not queued.
- CLEAR_REQ and WRITE in the same IDLE cycle → clear wins and the write is discarded. Same for READ: outputs hold.
- The index width is AW; no wrap past DEPTH-1 is ever used.
- RESET during CLEAR → immediate return to IDLE with every entry at RESET_VAL. No partial-clear state survives.
- No X propagation: every address value is in range because DEPTH is a power of two.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: a read in the same cycle as a non-discarded write to the same address returns DATA_W (write-first forwarding), per port independently.
  - Forwarding never applies to address 0 when R0_ZERO=1.
  - Forwarding never applies while BUSY.
- Not defined: read-first; the old contents are returned. No forwarding logic is synthesised.

Decomposition:
- Shared package reg_file_pkg holds:
  - the FSM state typedef (IDLE, CLEAR);
  - a localparam function for AW;
  - default WIDTH/DEPTH constants shared with the ALU/datapath.
- One sub-module: reg_file_clear_ctrl. It contains the FSM, the clear index counter and BUSY. It outputs the clear write enable and clear address, which the array muxes ahead of the user write port.

Test Plan (WIDTH=32, DEPTH=32, RESET_VAL=0, R0_ZERO=1 unless stated):
- Reset then READ addr 5/9 → DATA_R1=DATA_R2=0; BUSY=0.
- WRITE 0xDEADBEEF to addr 7; next cycle READ R1=7, R2=7 → both 0xDEADBEEF one cycle later.
- WRITE 0x12345678 to addr 0, then READ addr 0 → 0x00000000.
- Same-cycle WRITE addr 3 = 0xA5A5A5A5 with READ R1=3 (prior 0x1):
  - without macro → 0x00000001;
  - with REG_FILE_BYPASS_EN → 0xA5A5A5A5.
- Fill all 32 registers with their index, then pulse CLEAR_REQ:
  - BUSY high exactly 32 cycles;
  - WRITE of addr 4 = 0xFF mid-clear dropped;
  - afterwards all reads return 0.
- RESET_VAL=0xCAFE0000, pulse CLEAR_REQ, assert RESET at clear cycle 10 → BUSY drops immediately; all entries read 0xCAFE0000 (addr 0 reads 0); next CLEAR_REQ runs a full 32 cycles.
